parity_frame_gen: RTL



---
 rtl/parity_frame_gen.sv | 89 ++++++++
 1 files changed

// File: rtl/parity_frame_gen.sv
// Frame parity generator: XOR-folds accepted words, presents one even/odd parity bit per frame.
// Result visible the cycle after the closing word; in_ready is low while a result waits for par_ready.
module parity_frame_gen #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           odd,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic                           par_valid,
  output logic                           par_bit,
  input  logic                           par_ready,
  output logic [$clog2(MAX_WORDS+1)-1:0] word_count,
  output logic                           overflow
);

  localparam int CW = $clog2(MAX_WORDS+1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t          state, state_nxt;
  logic            acc, acc_nxt;
  logic            mode, mode_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic [CW-1:0]   cnt_inc;
  logic            ovf_nxt;
  logic            accept;

  assign in_ready  = en && (state != HOLD);
  assign accept    = in_valid && in_ready;
  assign par_valid = (state == HOLD);
  // Result is derived from held state, so it stays stable for the whole HOLD period.
  assign par_bit   = (state == HOLD) && (acc ^ mode);
  assign cnt_inc   = (state == IDLE) ? CW'(1) : word_count + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= 1'b0;
      mode       <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      mode       <= mode_nxt;
      word_count <= cnt_nxt;
      overflow   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    mode_nxt  = mode;
    cnt_nxt   = word_count;
    ovf_nxt   = overflow;
    unique case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_nxt = ((state == IDLE) ? 1'b0 : acc) ^ (^in_data);
          cnt_nxt = cnt_inc;
          if (state == IDLE) mode_nxt = odd;
          if (in_last || (cnt_inc == CW'(MAX_WORDS))) begin
            state_nxt = HOLD;
            // A word-limit close is only an overflow if the sender did not end the frame itself.
            if (!in_last) ovf_nxt = 1'b1;
          end else begin
            state_nxt = ACCUM;
          end
        end
      end
      HOLD: begin
        if (par_ready) begin
          state_nxt = IDLE;
          acc_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
